// File: rtl/systolic_ctrl.sv
// systolic_ctrl: job sequencer for the systolic array enables (load W, push W, load A, stream, unload).
// Latency: enables follow the registered state; first LOAD_W cycle is the cycle after start is accepted.
// Backpressure: UNLOAD advances only on out_ready; out_ready low holds the job in UNLOAD indefinitely.
// Optional build macro SA_CTRL_WEIGHT_REUSE_EN adds keep_weights to skip LOAD_W/PUSH_W when weights are resident.

module systolic_ctrl #(
  parameter int ARRAYWIDTH   = 4,
  parameter int CNT_W        = 8,
  parameter int RESULT_DELAY = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_rows,
  input  logic             abort,
  input  logic             out_ready,
`ifdef SA_CTRL_WEIGHT_REUSE_EN
  input  logic             keep_weights,
`endif
  output logic             busy,
  output logic             done,
  output logic             input_buffer_load_en,
  output logic             input_buffer_out_en,
  output logic             weight_buffer_load_en,
  output logic             weight_buffer_out_en,
  output logic             write_weight_en,
  output logic             output_buffer_load_en,
  output logic             output_buffer_out_en
);

  // Counter must reach RESULT_DELAY+M-1 at the largest M without wrapping, and also N-1.
  localparam int CW_A  = CNT_W + 1;
  localparam int CW_B  = $clog2(RESULT_DELAY + (1 << CNT_W));
  localparam int CW_C  = $clog2(ARRAYWIDTH + 1);
  localparam int CW_AB = (CW_A > CW_B) ? CW_A : CW_B;
  localparam int CW    = (CW_AB > CW_C) ? CW_AB : CW_C;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_PUSH_W, S_LOAD_A, S_STREAM, S_UNLOAD, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] m_q, m_d;
  logic [CW-1:0]    m_ext_q, m_ext_d;
  logic             unload_q;
`ifdef SA_CTRL_WEIGHT_REUSE_EN
  logic             wv_q, wv_d;
`endif

  // Registered-output next values, derived from the next state and counter
  logic busy_d, done_d, ibl_d, ibo_d, wbl_d, wbo_d, obl_d, unload_d;

  assign m_ext_q = {{(CW-CNT_W){1'b0}}, m_q};
  assign m_ext_d = {{(CW-CNT_W){1'b0}}, m_d};

  // Next-state and counter logic; abort overrides everything outside IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
`ifdef SA_CTRL_WEIGHT_REUSE_EN
    wv_d    = wv_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && (num_rows != '0)) begin
          m_d     = num_rows;
          cnt_d   = '0;
          state_d = S_LOAD_W;
`ifdef SA_CTRL_WEIGHT_REUSE_EN
          if (keep_weights && wv_q) state_d = S_LOAD_A;
`endif
        end
      end
      S_LOAD_W: begin
        if (cnt_q == CW'(ARRAYWIDTH - 1)) begin
          cnt_d   = '0;
          state_d = S_PUSH_W;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PUSH_W: begin
        if (cnt_q == CW'(ARRAYWIDTH - 1)) begin
          cnt_d   = '0;
          state_d = S_LOAD_A;
`ifdef SA_CTRL_WEIGHT_REUSE_EN
          wv_d    = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LOAD_A: begin
        if (cnt_q == m_ext_q - 1'b1) begin
          cnt_d   = '0;
          state_d = S_STREAM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STREAM: begin
        // Last stream cycle is the one capturing result row M-1
        if (cnt_q == CW'(RESULT_DELAY) + m_ext_q - 1'b1) begin
          cnt_d   = '0;
          state_d = S_UNLOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_UNLOAD: begin
        if (out_ready) begin
          if (cnt_q == m_ext_q - 1'b1) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
`ifdef SA_CTRL_WEIGHT_REUSE_EN
      // A partially pushed weight set cannot be trusted for reuse
      if ((state_q == S_LOAD_W) || (state_q == S_PUSH_W)) wv_d = 1'b0;
`endif
    end
  end

  // Output decode for the coming cycle so that every enable leaves a flop
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    ibl_d    = (state_d == S_LOAD_A);
    ibo_d    = (state_d == S_STREAM) && (cnt_d < m_ext_d);
    wbl_d    = (state_d == S_LOAD_W);
    wbo_d    = (state_d == S_PUSH_W);
    obl_d    = (state_d == S_STREAM) && (cnt_d >= CW'(RESULT_DELAY));
    unload_d = (state_d == S_UNLOAD);
  end

  // State, counters and registered enables
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q               <= S_IDLE;
      cnt_q                 <= '0;
      m_q                   <= '0;
      unload_q              <= 1'b0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      input_buffer_load_en  <= 1'b0;
      input_buffer_out_en   <= 1'b0;
      weight_buffer_load_en <= 1'b0;
      weight_buffer_out_en  <= 1'b0;
      write_weight_en       <= 1'b0;
      output_buffer_load_en <= 1'b0;
`ifdef SA_CTRL_WEIGHT_REUSE_EN
      wv_q                  <= 1'b0;
`endif
    end else begin
      state_q               <= state_d;
      cnt_q                 <= cnt_d;
      m_q                   <= m_d;
      unload_q              <= unload_d;
      busy                  <= busy_d;
      done                  <= done_d;
      input_buffer_load_en  <= ibl_d;
      input_buffer_out_en   <= ibo_d;
      weight_buffer_load_en <= wbl_d;
      weight_buffer_out_en  <= wbo_d;
      write_weight_en       <= wbo_d;
      output_buffer_load_en <= obl_d;
`ifdef SA_CTRL_WEIGHT_REUSE_EN
      wv_q                  <= wv_d;
`endif
    end
  end

  // Drain handshake is same-cycle: a row leaves whenever downstream is ready
  assign output_buffer_out_en = unload_q & out_ready;

endmodule
